// File: rtl/gate_selftest_pkg.sv
// Shared definitions for the 2-input gate self-test driver.
//   state_e       : driver FSM states
//   NUM_VEC       : number of input vectors applied per run
//   TT_*          : truth tables for common gates, bit i = y for {a,b}=i
//   settle_limit  : converts the settle parameter to the 8-bit counter range
package gate_selftest_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    REPORT = 2'd2
  } state_e;

  localparam int NUM_VEC = 4;

  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

  // The hold counter is 8 bits wide, so the settle count is taken modulo 256.
  function automatic logic [7:0] settle_limit(input int unsigned cycles);
    return cycles[7:0];
  endfunction

endpackage

// File: rtl/gate_selftest_driver_settle_timer.sv
// gate_settle_timer: 8-bit hold counter for one test vector.
//   clk    : clock
//   rst    : synchronous active-high reset (count to 0)
//   clr    : load 0 at the next edge instead of counting
//   expire : high while count equals SETTLE_CYCLES
module gate_settle_timer
  import gate_selftest_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic expire
);

  localparam logic [7:0] LIMIT = settle_limit(SETTLE_CYCLES);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q + 8'd1;
    if (clr) begin
      count_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == LIMIT);

endmodule

// File: rtl/gate_selftest_driver.sv
// gate_selftest_driver: drives a 2-input gate through {a,b} = 00,01,10,11,
// holds each vector SETTLE_CYCLES+1 cycles, compares y with TRUTH and
// publishes a per-vector mismatch mask at the end of the run.
//   clk      : clock
//   rst      : synchronous active-high reset
//   start    : begin a run (honoured in IDLE and REPORT)
//   a, b     : gate inputs (registered)
//   y        : gate output, sampled only on the last cycle of each vector
//   busy     : run in progress
//   done     : one-cycle end-of-run pulse
//   pass     : last run had no mismatches
//   fail_vec : bit i set if vector i mismatched in the last run
module gate_selftest_driver
  import gate_selftest_pkg::*;
#(
  parameter logic [3:0] TRUTH         = TT_OR,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_VEC - 1);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] fail_vec_q, fail_vec_d;
  logic [3:0] scratch_q, scratch_d;
  logic [3:0] scratch_upd;
  logic       timer_clr;
  logic       expire;

  gate_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timer_clr),
    .expire(expire)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_vec_d  = fail_vec_q;
    scratch_d   = scratch_q;
    timer_clr   = 1'b1;
    // Mismatch mask including the vector being compared this cycle.
    scratch_upd = scratch_q;
    if (y != TRUTH[idx_q]) begin
      scratch_upd[idx_q] = 1'b1;
    end

    case (state_q)
      // REPORT accepts start exactly like IDLE so runs can chain back-to-back.
      IDLE, REPORT: begin
        a_d     = 1'b0;
        b_d     = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          state_d    = APPLY;
          idx_d      = 2'd0;
          busy_d     = 1'b1;
          pass_d     = 1'b0;
          fail_vec_d = 4'd0;
          scratch_d  = 4'd0;
        end
      end
      APPLY: begin
        // Counter restarts from 0 on the edge that ends a vector.
        timer_clr = expire;
        if (expire) begin
          scratch_d = scratch_upd;
          if (idx_q == LAST_IDX) begin
            state_d    = REPORT;
            a_d        = 1'b0;
            b_d        = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            fail_vec_d = scratch_upd;
            pass_d     = (scratch_upd == 4'd0);
          end else begin
            idx_d      = idx_q + 2'd1;
            {a_d, b_d} = idx_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_vec_q <= 4'd0;
      scratch_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_vec_q <= fail_vec_d;
      scratch_q  <= scratch_d;
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail_vec = fail_vec_q;

endmodule

// File: tb/tb_gate_selftest_driver.sv
// Bench for gate_selftest_driver: three instances (OR/settle 2, AND/settle 2,
// OR/settle 0), each looped back through a behavioural gate whose function is
// a 4-entry lookup that the bench can change between runs.
module tb_gate_selftest_driver;
  import gate_selftest_pkg::*;

  localparam logic [3:0] INST_TRUTH  [3] = '{TT_OR, TT_AND, TT_OR};
  localparam int         INST_SETTLE [3] = '{2, 2, 0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start_v = 3'b000;
  logic [2:0] a_v, b_v, y_v, busy_v, done_v, pass_v;
  logic [3:0] fv_v  [3];
  logic [3:0] gfunc [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign y_v[0] = gfunc[0][{a_v[0], b_v[0]}];
  assign y_v[1] = gfunc[1][{a_v[1], b_v[1]}];
  assign y_v[2] = gfunc[2][{a_v[2], b_v[2]}];

  gate_selftest_driver #(.TRUTH(INST_TRUTH[0]), .SETTLE_CYCLES(INST_SETTLE[0])) u_dut (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]), .y(y_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .fail_vec(fv_v[0]));

  gate_selftest_driver #(.TRUTH(INST_TRUTH[1]), .SETTLE_CYCLES(INST_SETTLE[1])) u_and (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]), .y(y_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .fail_vec(fv_v[1]));

  gate_selftest_driver #(.TRUTH(INST_TRUTH[2]), .SETTLE_CYCLES(INST_SETTLE[2])) u_s0 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]), .y(y_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .fail_vec(fv_v[2]));

  typedef struct {
    int         sel;
    logic [3:0] gf;
    logic [3:0] exp_fv;
    logic       exp_pass;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input int s, input string tag, input int exp_pass, input int exp_fv);
    check({tag, "_a"},    int'(a_v[s]),    0);
    check({tag, "_b"},    int'(b_v[s]),    0);
    check({tag, "_busy"}, int'(busy_v[s]), 0);
    check({tag, "_done"}, int'(done_v[s]), 0);
    check({tag, "_pass"}, int'(pass_v[s]), exp_pass);
    check({tag, "_fv"},   int'(fv_v[s]),   exp_fv);
  endtask

  // One complete run on instance s with gate function gf. Expected values come
  // from arithmetic on the run shape: vector k occupies cycles k*(S+1)..,
  // the mismatch mask is the XOR of the gate function and the truth table.
  task automatic run_check(input int s, input logic [3:0] gf, input bit rand_start,
                           output logic [3:0] got_fv, output logic got_pass);
    int         hold;
    int         len;
    int         v;
    logic [3:0] exp_fv;
    hold     = INST_SETTLE[s] + 1;
    len      = 4 * hold;
    exp_fv   = gf ^ INST_TRUTH[s];
    got_fv   = 4'd0;
    got_pass = 1'b0;
    gfunc[s] = gf;
    @(negedge clk);
    start_v[s] = 1'b1;
    for (int c = 0; c <= len; c++) begin
      @(negedge clk);
      if (c < len) begin
        v = c / hold;
        check("run_busy", int'(busy_v[s]), 1);
        check("run_done", int'(done_v[s]), 0);
        check("run_ab",   int'({a_v[s], b_v[s]}), v);
        check("run_fv_clr", int'(fv_v[s]), 0);
        check("run_pass_clr", int'(pass_v[s]), 0);
      end else begin
        got_fv   = fv_v[s];
        got_pass = pass_v[s];
        check("end_done", int'(done_v[s]), 1);
        check("end_busy", int'(busy_v[s]), 0);
        check("end_ab",   int'({a_v[s], b_v[s]}), 0);
        check("end_fv",   int'(fv_v[s]), int'(exp_fv));
        check("end_pass", int'(pass_v[s]), int'(exp_fv == 4'd0));
      end
      // start must be low on the edge leaving REPORT, else a new run begins.
      start_v[s] = (rand_start && c < len) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    @(negedge clk);
    check_idle(s, "post", int'(exp_fv == 4'd0), int'(exp_fv));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       tbl [8];
    logic [3:0] fv;
    logic       ps;
    int         len;

    tbl[0] = '{0, TT_OR,   4'b0000, 1'b1};
    tbl[1] = '{0, 4'b0000, 4'b1110, 1'b0};
    tbl[2] = '{0, 4'b1111, 4'b0001, 1'b0};
    tbl[3] = '{0, TT_AND,  4'b0110, 1'b0};
    tbl[4] = '{1, TT_AND,  4'b0000, 1'b1};
    tbl[5] = '{0, TT_XOR,  4'b1000, 1'b0};
    tbl[6] = '{2, TT_OR,   4'b0000, 1'b1};
    tbl[7] = '{1, TT_NAND, 4'b1111, 1'b0};

    for (int i = 0; i < 3; i++) gfunc[i] = TT_OR;

    // Reset with start asserted: reset must win.
    start_v = 3'b111;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle(i, "rst", 0, 0);
    start_v = 3'b000;
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle(i, "idle", 0, 0);

    // Table-driven runs.
    for (int i = 0; i < 8; i++) begin
      run_check(tbl[i].sel, tbl[i].gf, 1'b0, fv, ps);
      check("tbl_fv",   int'(fv), int'(tbl[i].exp_fv));
      check("tbl_pass", int'(ps), int'(tbl[i].exp_pass));
    end

    // Reset while {a,b}=10: no done, nothing published.
    gfunc[0] = TT_OR;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_ab", int'({a_v[0], b_v[0]}), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle(0, "midrst", 0, 0);
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      check("midrst_nodone", int'(done_v[0]), 0);
      check("midrst_nobusy", int'(busy_v[0]), 0);
    end
    run_check(0, TT_OR, 1'b0, fv, ps);
    check("midrst_rerun_pass", int'(ps), 1);

    // start held high: runs chain, one REPORT cycle between them.
    len = 4 * (INST_SETTLE[0] + 1);
    @(negedge clk);
    start_v[0] = 1'b1;
    for (int c = 0; c <= 2 * len + 1; c++) begin
      int ph;
      @(negedge clk);
      ph = c % (len + 1);
      if (ph < len) begin
        check("b2b_busy", int'(busy_v[0]), 1);
        check("b2b_done", int'(done_v[0]), 0);
        check("b2b_ab",   int'({a_v[0], b_v[0]}), ph / (INST_SETTLE[0] + 1));
      end else begin
        check("b2b_done_pulse", int'(done_v[0]), 1);
        check("b2b_busy_low",   int'(busy_v[0]), 0);
        check("b2b_pass",       int'(pass_v[0]), 1);
      end
    end
    start_v[0] = 1'b0;
    @(negedge clk);
    check_idle(0, "b2b_end", 1, 0);

    // Randomised runs with random start noise during busy.
    for (int i = 0; i < 24; i++) begin
      run_check(int'($urandom_range(0, 2)), 4'($urandom), 1'b1, fv, ps);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
